lbp_hist: RTL and testbench

Downstream consumer of the LBP engine's output stream. Each `lbp_valid` beat carries an 8-bit LBP code. The block accumulates those codes into a 256-bin histogram held in a 1-cycle-latency RAM. After the frame's `finish` rising edge it streams the 256 bin counts out under a valid/ready handshake, clearing each bin as it is read so the next frame starts from zero.

---
 rtl/lbp_pkg.sv | 30 +++
 rtl/lbp_hist_if.sv | 24 ++
 rtl/lbp_hist_ram.sv | 41 ++++
 rtl/lbp_hist.sv | 144 ++++++++++++++
 tb/tb_lbp_hist.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lbp_pkg.sv
// Shared constants and types for the LBP histogram block.
// Image geometry, bin count and the readout FSM state encoding live here.
package lbp_pkg;

   localparam int IMG_W   = 128;
   localparam int IMG_H   = 128;
   localparam int NBINS   = 256;
   localparam int ADDR_W  = 14;
   localparam int COORD_W = 7;
   localparam int BIN_W   = 8;

   typedef enum logic [2:0] {
      ACCUM,
      DRAIN,
      RD,
      SHOW,
      DONE
   } hist_state_t;

   // Pixel address is {row, col}; a border pixel sits on the outermost ring.
   function automatic logic is_border(input logic [ADDR_W-1:0] addr);
      logic [COORD_W-1:0] row;
      logic [COORD_W-1:0] col;
      row = addr[ADDR_W-1 -: COORD_W];
      col = addr[COORD_W-1:0];
      return (row == '0) || (row == COORD_W'(IMG_H - 1)) ||
             (col == '0) || (col == COORD_W'(IMG_W - 1));
   endfunction

endpackage

// File: rtl/lbp_hist_if.sv
// Histogram readout stream: one bin index plus its count per valid/ready beat.
// The histogram block is the master; the consumer drives ready.
interface lbp_hist_if #(
   parameter int CNT_W = 15
);
   logic             hist_valid;
   logic             hist_ready;
   logic [7:0]       hist_bin;
   logic [CNT_W-1:0] hist_count;

   modport master (
      output hist_valid,
      output hist_bin,
      output hist_count,
      input  hist_ready
   );

   modport slave (
      input  hist_valid,
      input  hist_bin,
      input  hist_count,
      output hist_ready
   );
endinterface

// File: rtl/lbp_hist_ram.sv
// 256 x CNT_W histogram store: registered read (1-cycle latency), one write port.
// Entries are flops so reset returns every bin to zero at once.
module lbp_hist_ram
   import lbp_pkg::*;
#(
   parameter int CNT_W = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_en,
   input  logic [BIN_W-1:0]      rd_addr,
   output logic [CNT_W-1:0]      rd_data,
   input  logic                  wr_en,
   input  logic [BIN_W-1:0]      wr_addr,
   input  logic [CNT_W-1:0]      wr_data
);

   logic [CNT_W-1:0] mem [NBINS];

   generate
      for (genvar gi = 0; gi < NBINS; gi++) begin : g_entry
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               mem[gi] <= '0;
            end else if (wr_en && (wr_addr == BIN_W'(gi))) begin
               mem[gi] <= wr_data;
            end
         end
      end
   endgenerate

   // A same-cycle write is not visible to the read; the caller forwards instead.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: accumulates one code per cycle into 256 bins, then streams
// the bins out after a finish edge, clearing each bin as it is accepted.
module lbp_hist
   import lbp_pkg::*;
#(
   parameter bit EXCLUDE_BORDER = 1'b0,
   parameter int CNT_W          = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lbp_valid,
   input  logic [ADDR_W-1:0] lbp_addr,
   input  logic [BIN_W-1:0]  lbp_data,
   input  logic              finish,
   lbp_hist_if.master        hist,
   output logic [CNT_W-1:0]  pix_cnt,
   output logic              done
);

   hist_state_t      state_reg, state_next;
   logic             finish_reg;
   logic             finish_rise;
   logic [BIN_W-1:0] bin_reg, bin_next;

   logic             s1_valid_reg;
   logic [BIN_W-1:0] s1_bin_reg;
   logic             wr_valid_reg;
   logic [BIN_W-1:0] wr_bin_reg;
   logic [CNT_W-1:0] wr_val_reg;
   logic [CNT_W-1:0] pix_cnt_reg;

   logic             sample_ok;
   logic             handshake;
   logic [CNT_W-1:0] base_cnt;
   logic [CNT_W-1:0] inc_cnt;

   logic             ram_rd_en;
   logic [BIN_W-1:0] ram_rd_addr;
   logic [CNT_W-1:0] ram_rd_data;
   logic             ram_wr_en;
   logic [BIN_W-1:0] ram_wr_addr;
   logic [CNT_W-1:0] ram_wr_data;

   lbp_hist_ram #(
      .CNT_W (CNT_W)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (ram_rd_en),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_rd_data),
      .wr_en   (ram_wr_en),
      .wr_addr (ram_wr_addr),
      .wr_data (ram_wr_data)
   );

   assign finish_rise = finish && !finish_reg;
   assign sample_ok   = lbp_valid && (state_reg == ACCUM) &&
                        !(EXCLUDE_BORDER && is_border(lbp_addr));
   assign handshake   = (state_reg == SHOW) && hist.hist_ready;

   // The RAM misses a write made on the same edge as the read, so a bin hit
   // in consecutive cycles takes the value just written instead of rd_data.
   assign base_cnt = (wr_valid_reg && (wr_bin_reg == s1_bin_reg)) ? wr_val_reg : ram_rd_data;
   assign inc_cnt  = (base_cnt == '1) ? base_cnt : base_cnt + CNT_W'(1);

   always_comb begin
      state_next  = state_reg;
      bin_next    = bin_reg;
      ram_rd_en   = 1'b0;
      ram_rd_addr = lbp_data;
      ram_wr_en   = s1_valid_reg;
      ram_wr_addr = s1_bin_reg;
      ram_wr_data = inc_cnt;
      case (state_reg)
         ACCUM: begin
            ram_rd_en = sample_ok;
            if (finish_rise) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            bin_next   = '0;
            state_next = RD;
         end
         RD: begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = bin_reg;
            state_next  = SHOW;
         end
         SHOW: begin
            if (handshake) begin
               ram_wr_en   = 1'b1;
               ram_wr_addr = bin_reg;
               ram_wr_data = '0;
               bin_next    = bin_reg + BIN_W'(1);
               state_next  = (bin_reg == BIN_W'(NBINS - 1)) ? DONE : RD;
            end
         end
         DONE: begin
            state_next = ACCUM;
         end
         default: begin
            state_next = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ACCUM;
         finish_reg   <= 1'b0;
         bin_reg      <= '0;
         s1_valid_reg <= 1'b0;
         s1_bin_reg   <= '0;
         wr_valid_reg <= 1'b0;
         wr_bin_reg   <= '0;
         wr_val_reg   <= '0;
         pix_cnt_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         finish_reg   <= finish;
         bin_reg      <= bin_next;
         s1_valid_reg <= sample_ok;
         s1_bin_reg   <= lbp_data;
         wr_valid_reg <= s1_valid_reg;
         wr_bin_reg   <= s1_bin_reg;
         wr_val_reg   <= inc_cnt;
         if (state_reg == DONE) begin
            pix_cnt_reg <= '0;
         end else if (s1_valid_reg && (pix_cnt_reg != '1)) begin
            pix_cnt_reg <= pix_cnt_reg + CNT_W'(1);
         end
      end
   end

   // rd_data is only refreshed in RD, so the count holds for the whole SHOW stall.
   assign hist.hist_valid = (state_reg == SHOW);
   assign hist.hist_bin   = bin_reg;
   assign hist.hist_count = (state_reg == SHOW) ? ram_rd_data : '0;
   assign pix_cnt         = pix_cnt_reg;
   assign done            = (state_reg == DONE);

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: two instances (border filter off/on) fed the same
// stream; every readout bin is compared against hand-computed expectations.
module tb_lbp_hist;

   localparam int CNT_W = 15;

   logic             clk = 1'b0;
   logic             reset;
   logic             lbp_valid;
   logic [13:0]      lbp_addr;
   logic [7:0]       lbp_data;
   logic             finish;
   logic [CNT_W-1:0] pix0, pix1;
   logic             done0, done1;

   lbp_hist_if #(.CNT_W(CNT_W)) h0 ();
   lbp_hist_if #(.CNT_W(CNT_W)) h1 ();

   lbp_hist #(.EXCLUDE_BORDER(1'b0), .CNT_W(CNT_W)) dut0 (
      .clk       (clk),
      .reset     (reset),
      .lbp_valid (lbp_valid),
      .lbp_addr  (lbp_addr),
      .lbp_data  (lbp_data),
      .finish    (finish),
      .hist      (h0),
      .pix_cnt   (pix0),
      .done      (done0)
   );

   lbp_hist #(.EXCLUDE_BORDER(1'b1), .CNT_W(CNT_W)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .lbp_valid (lbp_valid),
      .lbp_addr  (lbp_addr),
      .lbp_data  (lbp_data),
      .finish    (finish),
      .hist      (h1),
      .pix_cnt   (pix1),
      .done      (done1)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [CNT_W-1:0] exp0 [256];
   logic [CNT_W-1:0] exp1 [256];
   int epix0, epix1;

   localparam logic [13:0] INNER = 14'h0081;  // row 1, col 1

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 256; i++) begin
         exp0[i] = '0;
         exp1[i] = '0;
      end
   endtask

   task automatic sample(input logic [13:0] a, input logic [7:0] d);
      lbp_valid = 1'b1;
      lbp_addr  = a;
      lbp_data  = d;
      tick();
      lbp_valid = 1'b0;
   endtask

   // finish must already be high; lat0 = edges already elapsed since it rose.
   task automatic readout(input bit rnd, input int stop_at, input int lat0, input bit junk,
                          input int frame);
      int lat;
      int w;
      int n;
      int hs;
      logic [7:0]       sb;
      logic [CNT_W-1:0] sc;
      lat = lat0;
      hs  = 0;
      h0.hist_ready = !rnd;
      h1.hist_ready = !rnd;
      if (junk) begin
         tick();
         lat++;
         lbp_valid = 1'b1;
         lbp_addr  = INNER;
         lbp_data  = 8'h11;
      end
      for (int i = 0; i < 256; i++) begin
         w = 0;
         while (!h0.hist_valid && w < 20) begin
            tick();
            w++;
            lat++;
         end
         if (h0.hist_valid !== 1'b1) begin
            chk("valid_timeout", 32'(h0.hist_valid), 32'd1);
            return;
         end
         if (i == 0) begin
            chk("first_valid_latency", 32'(lat), 32'd3);
            chk("pix_cnt0", 32'(pix0), 32'(epix0));
            chk("pix_cnt1", 32'(pix1), 32'(epix1));
         end
         if (i == 1 && !rnd) chk("bin_period", 32'(w), 32'd1);
         chk("hist_bin0", 32'(h0.hist_bin), 32'(i));
         chk("hist_count0", 32'(h0.hist_count), 32'(exp0[i]));
         chk("hist_bin1", 32'(h1.hist_bin), 32'(i));
         chk("hist_count1", 32'(h1.hist_count), 32'(exp1[i]));
         if (i == stop_at) return;
         if (rnd) begin
            n  = int'($urandom_range(0, 3));
            sb = h0.hist_bin;
            sc = h0.hist_count;
            for (int k = 0; k < n; k++) begin
               tick();
               chk("stall_valid", 32'(h0.hist_valid), 32'd1);
               chk("stall_bin", 32'(h0.hist_bin), 32'(sb));
               chk("stall_count", 32'(h0.hist_count), 32'(sc));
            end
            h0.hist_ready = 1'b1;
            h1.hist_ready = 1'b1;
         end
         tick();
         hs++;
         if (rnd) begin
            h0.hist_ready = 1'b0;
            h1.hist_ready = 1'b0;
         end
      end
      lbp_valid = 1'b0;
      chk("handshakes", 32'(hs), 32'd256);
      chk("done0_pulse", 32'(done0), 32'd1);
      chk("done1_pulse", 32'(done1), 32'd1);
      tick();
      chk("done0_clear", 32'(done0), 32'd0);
      chk("pix0_cleared", 32'(pix0), 32'd0);
      chk("pix1_cleared", 32'(pix1), 32'd0);
      repeat (4) tick();
      chk("no_retrigger", 32'(h0.hist_valid), 32'd0);
      finish = 1'b0;
      h0.hist_ready = 1'b0;
      h1.hist_ready = 1'b0;
      tick();
      $display("[TB] frame %0d readout: %0d bins handshaked", frame, hs);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      lbp_valid = 1'b0;
      lbp_addr = '0;
      lbp_data = '0;
      finish = 1'b0;
      h0.hist_ready = 1'b0;
      h1.hist_ready = 1'b0;
      repeat (3) tick();
      chk("rst_hist_valid", 32'(h0.hist_valid), 32'd0);
      chk("rst_hist_bin", 32'(h0.hist_bin), 32'd0);
      chk("rst_hist_count", 32'(h0.hist_count), 32'd0);
      chk("rst_pix_cnt", 32'(pix0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      reset = 1'b0;
      tick();
      $display("[TB] reset released");

      // Frame 1: all-zero image; last sample coincides with the finish edge.
      clear_exp();
      exp0[0] = 15'd16384; epix0 = 16384;
      exp1[0] = 15'd15876; epix1 = 15876;
      for (int i = 0; i < 16384; i++) begin
         lbp_valid = 1'b1;
         lbp_addr  = 14'(i);
         lbp_data  = 8'h00;
         if (i == 16383) finish = 1'b1;
         tick();
      end
      lbp_valid = 1'b0;
      readout(1'b0, 256, 1, 1'b0, 1);

      // Frame 2: forwarding and two-apart paths, random ready, samples during readout.
      clear_exp();
      exp0[8'h5A] = 15'd7; exp1[8'h5A] = 15'd7;
      exp0[8'h3C] = 15'd2; exp1[8'h3C] = 15'd2;
      epix0 = 9; epix1 = 9;
      repeat (5) sample(INNER, 8'h5A);
      sample(INNER, 8'h5A);
      sample(INNER, 8'h3C);
      sample(INNER, 8'h5A);
      sample(INNER, 8'h3C);
      finish = 1'b1;
      readout(1'b1, 256, 0, 1'b1, 2);

      // Frame 3: clear-on-read leaves only this frame's codes.
      clear_exp();
      exp0[8'hFF] = 15'd3; exp1[8'hFF] = 15'd3;
      epix0 = 3; epix1 = 3;
      repeat (3) sample(INNER, 8'hFF);
      finish = 1'b1;
      readout(1'b0, 256, 0, 1'b0, 3);

      // Frame 4: abort the readout with reset while bin 100 is shown.
      clear_exp();
      exp0[100] = 15'd2; exp1[100] = 15'd2;
      epix0 = 2; epix1 = 2;
      repeat (2) sample(INNER, 8'd100);
      finish = 1'b1;
      readout(1'b0, 100, 0, 1'b0, 4);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_hist_valid", 32'(h0.hist_valid), 32'd0);
      chk("abort_hist_bin", 32'(h0.hist_bin), 32'd0);
      chk("abort_hist_count", 32'(h0.hist_count), 32'd0);
      chk("abort_pix_cnt", 32'(pix0), 32'd0);
      chk("abort_done", 32'(done0), 32'd0);
      finish = 1'b0;
      h0.hist_ready = 1'b0;
      h1.hist_ready = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      $display("[TB] reset applied mid-readout");

      // Frame 5: one sample after the abort must read back exactly 1.
      clear_exp();
      exp0[100] = 15'd1; exp1[100] = 15'd1;
      epix0 = 1; epix1 = 1;
      sample(INNER, 8'd100);
      finish = 1'b1;
      readout(1'b0, 256, 0, 1'b0, 5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
